// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd feeder: FSM state encoding and timing constants.
package gcd_pkg;

    localparam int GCD_WIDTH      = 32;
    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        HOLD,
        GAP
    } gcdState_e;

endpackage

// File: rtl/gcd_fifo.sv
// Operand-pair FIFO for the gcd feeder.
// The full flag is a register, so a push is refused whenever the FIFO is full,
// even if a pop happens in the same cycle. Pointers wrap modulo DEPTH (power of two).
module gcd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [DW-1:0] pushData_i,
    input  logic          pop_i,
    output logic [DW-1:0] popData_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          doPush;
    logic          doPop;

    // Work out which transfers actually happen and the resulting pointers, count and full flag.
    always_comb begin
        doPush  = push_i && !full_q;
        doPop   = pop_i && (count_q != '0);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (!doPush && doPop) begin
            count_d = count_q - 1'b1;
        end
        full_d = (count_d == (AW+1)'(DEPTH));
    end

    // Pointer, occupancy and full-flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign popData_o = mem_q[rdPtr_q];
    assign full_o    = full_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/gcd_feeder.sv
// gcd_feeder: queues operand pairs and feeds them one at a time to an external gcd unit,
// returning results in acceptance order over a valid/ready stream.
// Optional macro GCD_FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that ends a hung
// operation with out_result=0 and out_err=1; without it out_err is tied low.
module gcd_feeder
    import gcd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err
);

    localparam int GCW = $clog2(GAP_CYCLES + 1);

    gcdState_e        state_q, state_d;
    logic [WIDTH-1:0] gcdA_q, gcdA_d;
    logic [WIDTH-1:0] gcdB_q, gcdB_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [GCW-1:0]   gapCnt_q, gapCnt_d;
    logic [2*WIDTH-1:0] headData;
    logic [WIDTH-1:0] headA;
    logic [WIDTH-1:0] headB;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pop;

`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    logic [WDW-1:0]   wdCnt_q, wdCnt_d;
    logic             err_q, err_d;
`endif

    gcd_fifo #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH)
    ) uFifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (in_valid),
        .pushData_i ({in_a, in_b}),
        .pop_i      (pop),
        .popData_o  (headData),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    assign headA = headData[2*WIDTH-1:WIDTH];
    assign headB = headData[WIDTH-1:0];

    // Next-state and output decode: one operation in flight, zero operands short-circuit to HOLD.
    always_comb begin
        state_d   = state_q;
        gcdA_d    = gcdA_q;
        gcdB_d    = gcdB_q;
        result_d  = result_q;
        gapCnt_d  = gapCnt_q;
        pop       = 1'b0;
        gcd_start = 1'b0;
`ifdef GCD_FEEDER_TIMEOUT_EN
        wdCnt_d   = wdCnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop    = 1'b1;
                    gcdA_d = headA;
                    gcdB_d = headB;
                    if ((headA == '0) || (headB == '0)) begin
                        result_d = (headA == '0) ? headB : headA;
`ifdef GCD_FEEDER_TIMEOUT_EN
                        err_d    = 1'b0;
`endif
                        state_d  = HOLD;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                gcd_start = 1'b1;
                state_d   = ARM;
            end
            ARM: begin
`ifdef GCD_FEEDER_TIMEOUT_EN
                wdCnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (gcd_done) begin
                    result_d = gcd_result;
`ifdef GCD_FEEDER_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = HOLD;
                end
`ifdef GCD_FEEDER_TIMEOUT_EN
                else if (wdCnt_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = HOLD;
                end else begin
                    wdCnt_d  = wdCnt_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    gapCnt_d = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gapCnt_q == GCW'(GAP_CYCLES - 1)) begin
                    state_d  = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gcdA_q   <= '0;
            gcdB_q   <= '0;
            result_q <= '0;
            gapCnt_q <= '0;
`ifdef GCD_FEEDER_TIMEOUT_EN
            wdCnt_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gcdA_q   <= gcdA_d;
            gcdB_q   <= gcdB_d;
            result_q <= result_d;
            gapCnt_q <= gapCnt_d;
`ifdef GCD_FEEDER_TIMEOUT_EN
            wdCnt_q  <= wdCnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign in_ready   = !fifoFull;
    assign gcd_a      = gcdA_q;
    assign gcd_b      = gcdB_q;
    assign out_valid  = (state_q == HOLD);
    assign out_result = result_q;
`ifdef GCD_FEEDER_TIMEOUT_EN
    assign out_err    = err_q;
`else
    assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed self-checking bench for gcd_feeder with a behavioural gcd unit attached.
// The timeout scenario is included only when GCD_FEEDER_TIMEOUT_EN is defined.
module tb_gcd_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        gcd_start;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic        gcd_done;
    logic [31:0] gcd_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;

    int          checks = 0;
    int          failures = 0;
    int          startCount = 0;
    int          hsCount = 0;
    logic [31:0] resQ[$];

    int          mLatency;
    bit          mHang;
    int          mCnt;
    logic [31:0] mA;
    logic [31:0] mB;

    gcd_feeder #(
        .DEPTH (4),
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .gcd_start  (gcd_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gcdRef(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural gcd unit: done is a level that stays high (stale) until one cycle after the next start.
    always @(posedge clk) begin
        if (!reset_n) begin
            mCnt       <= 0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
        end else if (gcd_start) begin
            mCnt <= mLatency;
            mA   <= gcd_a;
            mB   <= gcd_b;
        end else if (mCnt != 0) begin
            mCnt <= mCnt - 1;
            if (mCnt == 1 && !mHang) begin
                gcd_done   <= 1'b1;
                gcd_result <= gcdRef(mA, mB);
            end else begin
                gcd_done   <= 1'b0;
            end
        end
    end

    // Monitor start pulses and completed result handshakes.
    always @(posedge clk) begin
        if (reset_n && gcd_start) begin
            startCount++;
        end
        if (reset_n && out_valid && out_ready) begin
            hsCount++;
            resQ.push_back(out_result);
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        int   guard;
        logic accepted;
        guard    = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!accepted && guard < 300) begin
            accepted = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checkOutput("pushAccepted", accepted, 1);
        end
    endtask

    task automatic waitValid(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        int          s0;
        int          h0;
        int          k;
        logic [31:0] obs;
        logic [31:0] pa[6]     = '{12, 35, 81, 17, 1000, 99};
        logic [31:0] pb[6]     = '{8, 21, 27, 5, 250, 66};
        logic [31:0] exp031[6] = '{4, 7, 27, 1, 250, 33};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        mLatency  = 3;
        mHang     = 1'b0;
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstStart", gcd_start, 0);
        checkOutput("rstGcdA", gcd_a, 0);
        checkOutput("rstGcdB", gcd_b, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutResult", out_result, 0);
        checkOutput("rstOutErr", out_err, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        $display("[TB] single pair 3430,2060");
        s0 = startCount;
        applyStimulus(3430, 2060);
        checkOutput("t030NoStartYet", gcd_start, 0);
        tick();
        checkOutput("t030Start", gcd_start, 1);
        checkOutput("t030GcdA", gcd_a, 3430);
        checkOutput("t030GcdB", gcd_b, 2060);
        tick();
        checkOutput("t030StartOnePulse", gcd_start, 0);
        waitValid(50, n);
        checkOutput("t030Valid", out_valid, 1);
        checkOutput("t030Latency", n, 4);
        checkOutput("t030Result", out_result, 10);
        checkOutput("t030Err", out_err, 0);
        checkOutput("t030GcdAHeld", gcd_a, 3430);
        checkOutput("t030GcdBHeld", gcd_b, 2060);
        checkOutput("t030StartCount", startCount - s0, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t030ValidDrop", out_valid, 0);
        repeat (5) tick();

        $display("[TB] back-pressure during HOLD");
        s0 = startCount;
        applyStimulus(48, 18);
        applyStimulus(100, 75);
        waitValid(50, n);
        checkOutput("t033Valid", out_valid, 1);
        checkOutput("t033Result", out_result, 6);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t033HoldValid", out_valid, 1);
            checkOutput("t033HoldResult", out_result, 6);
        end
        checkOutput("t033NoNewStart", startCount - s0, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t033Gap1Valid", out_valid, 0);
        checkOutput("t033Gap1Start", gcd_start, 0);
        tick();
        checkOutput("t033Gap2Start", gcd_start, 0);
        tick();
        checkOutput("t033IdleStart", gcd_start, 0);
        tick();
        checkOutput("t033NextStart", gcd_start, 1);
        checkOutput("t033NextGcdA", gcd_a, 100);
        checkOutput("t033NextGcdB", gcd_b, 75);
        waitValid(50, n);
        checkOutput("t033NextLatency", n, 5);
        checkOutput("t033NextResult", out_result, 25);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (5) tick();

        $display("[TB] zero operands bypass the gcd unit");
        out_ready = 1'b1;
        s0 = startCount;
        applyStimulus(0, 42);
        applyStimulus(0, 0);
        checkOutput("t032Valid1", out_valid, 1);
        checkOutput("t032Result1", out_result, 42);
        checkOutput("t032Err1", out_err, 0);
        tick();
        checkOutput("t032Gap", out_valid, 0);
        waitValid(50, n);
        checkOutput("t032Valid2", out_valid, 1);
        checkOutput("t032Spacing", n, 3);
        checkOutput("t032Result2", out_result, 0);
        checkOutput("t032NoStart", startCount - s0, 0);
        tick();
        out_ready = 1'b0;
        repeat (5) tick();

        $display("[TB] six pairs through a four-entry FIFO");
        mLatency  = 10;
        out_ready = 1'b1;
        resQ.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pa[i], pb[i]);
        end
        checkOutput("t031FullBackpressure", in_ready, 0);
        applyStimulus(pa[5], pb[5]);
        k = 0;
        while (resQ.size() < 6 && k < 500) begin
            tick();
            k++;
        end
        checkOutput("t031ResultCount", resQ.size(), 6);
        for (int i = 0; i < 6; i++) begin
            obs = (i < resQ.size()) ? resQ[i] : 32'hFFFF_FFFF;
            checkOutput($sformatf("t031Result%0d", i), obs, exp031[i]);
        end
        checkOutput("t031ReadyAfterDrain", in_ready, 1);
        out_ready = 1'b0;
        mLatency  = 3;
        repeat (5) tick();

        $display("[TB] reset while waiting with three pairs queued");
        mHang     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(20, 30);
        applyStimulus(44, 11);
        applyStimulus(9, 3);
        applyStimulus(14, 21);
        repeat (3) tick();
        s0      = startCount;
        h0      = hsCount;
        reset_n = 1'b0;
        tick();
        checkOutput("t034InReady", in_ready, 1);
        checkOutput("t034Start", gcd_start, 0);
        checkOutput("t034GcdA", gcd_a, 0);
        checkOutput("t034GcdB", gcd_b, 0);
        checkOutput("t034OutValid", out_valid, 0);
        checkOutput("t034OutResult", out_result, 0);
        checkOutput("t034OutErr", out_err, 0);
        reset_n = 1'b1;
        mHang   = 1'b0;
        repeat (20) tick();
        checkOutput("t034NoResult", hsCount - h0, 0);
        checkOutput("t034NoStart", startCount - s0, 0);
        checkOutput("t034ReadyAfter", in_ready, 1);
        out_ready = 1'b0;

`ifdef GCD_FEEDER_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        mHang = 1'b1;
        applyStimulus(9, 6);
        tick();
        checkOutput("t035Start", gcd_start, 1);
        waitValid(1100, n);
        checkOutput("t035Valid", out_valid, 1);
        checkOutput("t035Latency", n, 1026);
        checkOutput("t035Err", out_err, 1);
        checkOutput("t035Result", out_result, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mHang     = 1'b0;
        repeat (5) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
